// File: rtl/tx_frame_ctrl.sv
// tx_frame_ctrl -- OFDM transmit frame sequencer.
//
// A frame is num_sym payload symbols. Each symbol takes SYM_LEN clk_80 slots,
// and the PRBS source is asked for bits during the first BIT_WIN of them.
// GAP_SYMS idle symbol slots follow, and then a one-cycle DONE.
//
// Ports
//   clk_80     in   1   80 MHz clock
//   rst_n      in   1   synchronous active-low reset
//   start      in   1   single-cycle frame request (accepted only in IDLE)
//   num_sym    in   8   symbols in the frame, sampled with start
//   abort      in   1   ends the frame after the current symbol
//   trig_en    out  1   registered bit-request enable to the PRBS source
//   sym_start  out  1   pulse on slot 0 of each payload symbol
//   sym_idx    out  8   current payload symbol index
//   last_sym   out  1   high throughout the final payload symbol
//   busy       out  1   frame in progress (state != IDLE)
//   done       out  1   frame-complete pulse
//   aborted    out  1   with done: the frame was cut short
//   err        out  1   pulse after a start with num_sym == 0
//   frame_cnt  out  16  completed frames, wraps
module tx_frame_ctrl #(
    parameter int SYM_LEN  = 320,
    parameter int BIT_WIN  = 192,
    parameter int GAP_SYMS = 2
) (
    input  logic        clk_80,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  num_sym,
    input  logic        abort,
    output logic        trig_en,
    output logic        sym_start,
    output logic [7:0]  sym_idx,
    output logic        last_sym,
    output logic        busy,
    output logic        done,
    output logic        aborted,
    output logic        err,
    output logic [15:0] frame_cnt
);

    localparam int SW      = (SYM_LEN > 1) ? $clog2(SYM_LEN) : 1;
    localparam int GAP_LEN = GAP_SYMS * SYM_LEN;
    localparam int GW      = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

    typedef enum logic [1:0] {IDLE, SYMBOL, GAP, DONE} state_t;

    state_t          r_state, w_nstate;
    logic [SW-1:0]   r_slot, w_nslot;
    logic [GW-1:0]   r_gap, w_ngap;
    logic [7:0]      r_sym, w_nsym;
    logic [7:0]      r_nlat, w_nnlat;
    logic            r_pend, w_npend;
    logic [15:0]     r_fcnt, w_nfcnt;
    logic            r_trig, w_ntrig;
    logic            r_err, w_err;
    logic            w_last;

    // n_lat is never 0 while in SYMBOL, so the wrap of n_lat-1 at 0 is harmless
    assign w_last = (r_sym == r_nlat - 8'd1);

    always_comb begin
        w_nstate = r_state;
        w_nslot  = r_slot;
        w_ngap   = r_gap;
        w_nsym   = r_sym;
        w_nnlat  = r_nlat;
        w_npend  = r_pend;
        w_nfcnt  = r_fcnt;
        w_err    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (num_sym != 8'd0) begin
                        w_nnlat  = num_sym;
                        w_nsym   = 8'd0;
                        w_nslot  = '0;
                        w_npend  = 1'b0;
                        w_nstate = SYMBOL;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            SYMBOL: begin
                if (abort)
                    w_npend = 1'b1;
                if (r_slot == SW'(SYM_LEN - 1)) begin
                    w_nslot = '0;
                    // abort in the last slot takes effect on this very boundary
                    if (w_last || r_pend || abort) begin
                        w_ngap   = '0;
                        w_nstate = (GAP_SYMS > 0) ? GAP : DONE;
                    end else begin
                        w_nsym = r_sym + 8'd1;
                    end
                end else begin
                    w_nslot = r_slot + SW'(1);
                end
            end
            GAP: begin
                if (r_gap == GW'(GAP_LEN - 1))
                    w_nstate = DONE;
                else
                    w_ngap = r_gap + GW'(1);
            end
            DONE: begin
                w_nfcnt  = r_fcnt + 16'd1;
                w_npend  = 1'b0;
                w_nstate = IDLE;
            end
            default: w_nstate = IDLE;
        endcase
        // trig_en is registered, so it is computed from the next-cycle state
        w_ntrig = (w_nstate == SYMBOL) && (w_nslot < SW'(BIT_WIN));
    end

    always_ff @(posedge clk_80) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_slot  <= '0;
            r_gap   <= '0;
            r_sym   <= 8'd0;
            r_nlat  <= 8'd0;
            r_pend  <= 1'b0;
            r_fcnt  <= 16'd0;
            r_trig  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_nstate;
            r_slot  <= w_nslot;
            r_gap   <= w_ngap;
            r_sym   <= w_nsym;
            r_nlat  <= w_nnlat;
            r_pend  <= w_npend;
            r_fcnt  <= w_nfcnt;
            r_trig  <= w_ntrig;
            r_err   <= w_err;
        end
    end

    assign trig_en   = r_trig;
    assign sym_start = (r_state == SYMBOL) && (r_slot == '0);
    assign sym_idx   = r_sym;
    assign last_sym  = (r_state == SYMBOL) && w_last;
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign aborted   = (r_state == DONE) && r_pend;
    assign err       = r_err;
    assign frame_cnt = r_fcnt;

endmodule

// File: tb/tb_tx_frame_ctrl.sv
module tb_tx_frame_ctrl;
    localparam int SL = 320;
    localparam int BW = 192;
    localparam int GS = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, abort = 1'b0;
    logic [7:0] num = 8'd0;
    logic trig_en, sym_start, last_sym, busy, done, aborted, err;
    logic [7:0] sym_idx;
    logic [15:0] frame_cnt;

    // GAP_SYMS=0 instance
    logic start0 = 1'b0, abort0 = 1'b0;
    logic [7:0] num0 = 8'd0;
    logic trig_0, ss_0, last_0, busy_0, done_0, abt_0, err_0;
    logic [7:0] idx_0;
    logic [15:0] fc_0;

    // short-symbol instance for the N=255 run
    logic start_s = 1'b0, abort_s = 1'b0;
    logic [7:0] num_s = 8'd0;
    logic trig_s, ss_s, last_s, busy_s, done_s, abt_s, err_s;
    logic [7:0] idx_s;
    logic [15:0] fc_s;

    tx_frame_ctrl dut (
        .clk_80(clk), .rst_n(rst_n), .start(start), .num_sym(num), .abort(abort),
        .trig_en(trig_en), .sym_start(sym_start), .sym_idx(sym_idx), .last_sym(last_sym),
        .busy(busy), .done(done), .aborted(aborted), .err(err), .frame_cnt(frame_cnt));

    tx_frame_ctrl #(.SYM_LEN(320), .BIT_WIN(192), .GAP_SYMS(0)) dut0 (
        .clk_80(clk), .rst_n(rst_n), .start(start0), .num_sym(num0), .abort(abort0),
        .trig_en(trig_0), .sym_start(ss_0), .sym_idx(idx_0), .last_sym(last_0),
        .busy(busy_0), .done(done_0), .aborted(abt_0), .err(err_0), .frame_cnt(fc_0));

    tx_frame_ctrl #(.SYM_LEN(8), .BIT_WIN(4), .GAP_SYMS(1)) dut_s (
        .clk_80(clk), .rst_n(rst_n), .start(start_s), .num_sym(num_s), .abort(abort_s),
        .trig_en(trig_s), .sym_start(ss_s), .sym_idx(idx_s), .last_sym(last_s),
        .busy(busy_s), .done(done_s), .aborted(abt_s), .err(err_s), .frame_cnt(fc_s));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0, bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model: frame timeline by arithmetic ----------------
    bit m_ok = 0, m_act = 0, m_err = 0, m_abt = 0;
    int m_rel = 0, m_n = 0, m_neff = 0, m_fcnt = 0;
    bit e_trig, e_ss, e_last, e_busy, e_done, e_abt;
    int e_idx, e_slot, e_tot;

    // observation counters for directed checks
    int trig_cnt, busy_cnt, done_cyc, ls_first, ls_last, err_cyc;
    bit abt_seen;
    int ss_q[$];
    int done0_cyc, ss0_cyc, done_s_cyc, max_idx_s;

    task automatic clr_mon();
        trig_cnt = 0; busy_cnt = 0; done_cyc = -1; ls_first = -1; ls_last = -1;
        err_cyc = -1; abt_seen = 0; ss_q.delete();
    endtask

    always @(negedge clk) begin
        if (m_ok) begin
            e_trig = 0; e_ss = 0; e_last = 0; e_busy = 0; e_done = 0; e_abt = 0; e_idx = -1;
            if (m_act) begin
                e_busy = 1;
                e_tot  = SL * (m_neff + GS) + 1;
                if (m_rel <= SL * m_neff) begin
                    e_slot = (m_rel - 1) % SL;
                    e_idx  = (m_rel - 1) / SL;
                    e_trig = (e_slot < BW);
                    e_ss   = (e_slot == 0);
                    e_last = (e_idx == m_n - 1);
                end else if (m_rel == e_tot) begin
                    e_done = 1;
                    e_abt  = m_abt;
                end
            end
            chk("trig_en",   int'(trig_en),   int'(e_trig));
            chk("sym_start", int'(sym_start), int'(e_ss));
            chk("last_sym",  int'(last_sym),  int'(e_last));
            chk("busy",      int'(busy),      int'(e_busy));
            chk("done",      int'(done),      int'(e_done));
            chk("aborted",   int'(aborted),   int'(e_abt));
            chk("err",       int'(err),       int'(m_err));
            chk("frame_cnt", int'(frame_cnt), m_fcnt % 65536);
            if (e_idx >= 0) chk("sym_idx", int'(sym_idx), e_idx);
        end

        if (trig_en === 1'b1) trig_cnt++;
        if (busy === 1'b1) busy_cnt++;
        if (sym_start === 1'b1) ss_q.push_back(cyc);
        if (last_sym === 1'b1) begin
            if (ls_first < 0) ls_first = cyc;
            ls_last = cyc;
        end
        if (err === 1'b1) err_cyc = cyc;
        if (done === 1'b1) begin done_cyc = cyc; abt_seen = aborted; end
        if (done_0 === 1'b1) done0_cyc = cyc;
        if (ss_0 === 1'b1) ss0_cyc = cyc;
        if (done_s === 1'b1) done_s_cyc = cyc;
        if (busy_s === 1'b1 && int'(idx_s) > max_idx_s) max_idx_s = int'(idx_s);

        // advance the model using the inputs the coming edge will sample
        if (!rst_n) begin
            m_ok = 1; m_act = 0; m_err = 0; m_fcnt = 0;
        end else if (m_ok) begin
            m_err = 0;
            if (m_act) begin
                if (m_rel <= SL * m_neff && abort) begin
                    m_abt = 1;
                    if ((m_rel - 1) / SL + 1 < m_neff) m_neff = (m_rel - 1) / SL + 1;
                end
                if (m_rel == SL * (m_neff + GS) + 1) begin
                    m_act = 0;
                    m_fcnt++;
                end else begin
                    m_rel++;
                end
            end else if (start) begin
                if (num == 8'd0) m_err = 1;
                else begin m_act = 1; m_rel = 1; m_n = int'(num); m_neff = int'(num); m_abt = 0; end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int n, output int c0);
        clr_mon();
        num = 8'(n);
        start = 1'b1;
        c0 = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int lim);
        int k = 0;
        while (done_cyc < 0 && k < lim) begin tick(); k++; end
        if (done_cyc < 0) chk({nm, "_timeout"}, 0, 1);
    endtask

    initial begin
        int c0;
        clr_mon();
        done0_cyc = -1; ss0_cyc = -1; done_s_cyc = -1; max_idx_s = 0;

        // reset state
        repeat (3) tick();
        chk("rst_frame_cnt", int'(frame_cnt), 0);
        chk("rst_sym_idx",   int'(sym_idx),   0);
        chk("rst_busy",      int'(busy),      0);
        chk("rst_trig",      int'(trig_en),   0);
        rst_n = 1'b1;
        tick();
        abort = 1'b1; tick(); abort = 1'b0; tick();   // abort while idle: no effect

        // single-symbol frame
        run_frame(1, c0);
        wait_done("t1", 1100);
        chk("t1_done_cyc", done_cyc - c0, 961);
        chk("t1_trig_cnt", trig_cnt, 192);
        chk("t1_busy_cnt", busy_cnt, 961);
        chk("t1_aborted",  int'(abt_seen), 0);
        chk("t1_frame_cnt", int'(frame_cnt), 1);

        // three symbols
        run_frame(3, c0);
        wait_done("t2", 1800);
        chk("t2_ss_count", ss_q.size(), 3);
        if (ss_q.size() == 3) begin
            chk("t2_ss0", ss_q[0] - c0, 1);
            chk("t2_ss1", ss_q[1] - c0, 321);
            chk("t2_ss2", ss_q[2] - c0, 641);
        end
        chk("t2_trig_cnt",  trig_cnt, 576);
        chk("t2_last_from", ls_first - c0, 641);
        chk("t2_last_to",   ls_last - c0, 960);
        chk("t2_done_cyc",  done_cyc - c0, 1601);
        chk("t2_frame_cnt", int'(frame_cnt), 2);

        // zero-length request, then a start while busy
        clr_mon();
        num = 8'd0; start = 1'b1; c0 = cyc; tick(); start = 1'b0; tick();
        chk("t3_err_cyc", err_cyc - c0, 1);
        chk("t3_busy_cnt", busy_cnt, 0);
        run_frame(1, c0);
        repeat (99) tick();
        num = 8'd2; start = 1'b1; tick(); start = 1'b0;
        wait_done("t3", 1100);
        chk("t3_done_cyc", done_cyc - c0, 961);
        chk("t3_no_err",   err_cyc, -1);
        chk("t3_frame_cnt", int'(frame_cnt), 3);

        // abort at slot 50 of symbol 1
        run_frame(5, c0);
        while (cyc < c0 + 371) tick();
        abort = 1'b1; tick(); abort = 1'b0;
        wait_done("t4", 2000);
        chk("t4_done_cyc", done_cyc - c0, 1281);
        chk("t4_aborted",  int'(abt_seen), 1);
        chk("t4_trig_cnt", trig_cnt, 384);

        // abort on the last slot of symbol 0
        run_frame(3, c0);
        while (cyc < c0 + 320) tick();
        abort = 1'b1; tick(); abort = 1'b0;
        wait_done("t5", 1800);
        chk("t5_done_cyc", done_cyc - c0, 961);
        chk("t5_aborted",  int'(abt_seen), 1);
        chk("t5_trig_cnt", trig_cnt, 192);
        chk("t5_frame_cnt", int'(frame_cnt), 5);

        // reset at slot 100 of symbol 0, with a start held during reset
        run_frame(1, c0);
        while (cyc < c0 + 101) tick();
        rst_n = 1'b0; start = 1'b1; num = 8'd4;
        tick();
        chk("t6_trig_after_rst", int'(trig_en), 0);
        chk("t6_busy_after_rst", int'(busy), 0);
        chk("t6_fcnt_after_rst", int'(frame_cnt), 0);
        rst_n = 1'b1; start = 1'b0;
        tick(); tick();
        chk("t6_no_done", done_cyc, -1);
        chk("t6_busy_idle", int'(busy), 0);
        run_frame(1, c0);
        wait_done("t6", 1100);
        chk("t6_done_cyc", done_cyc - c0, 961);
        chk("t6_frame_cnt", int'(frame_cnt), 1);

        // GAP_SYMS=0, back-to-back frames
        done0_cyc = -1; ss0_cyc = -1;
        num0 = 8'd2; start0 = 1'b1; c0 = cyc; tick(); start0 = 1'b0;
        for (int k = 0; k < 800 && done0_cyc < 0; k++) tick();
        chk("t7_done_cyc", done0_cyc - c0, 641);
        chk("t7_start_cyc", cyc - c0, 642);
        start0 = 1'b1; tick(); start0 = 1'b0; tick();
        chk("t7_ss_cyc", ss0_cyc - c0, 643);

        // N=255 on a short-symbol instance: no index wrap
        done_s_cyc = -1; max_idx_s = 0;
        num_s = 8'd255; start_s = 1'b1; c0 = cyc; tick(); start_s = 1'b0;
        for (int k = 0; k < 2200 && done_s_cyc < 0; k++) tick();
        chk("t8_done_cyc", done_s_cyc - c0, 2049);
        chk("t8_max_idx",  max_idx_s, 254);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tx_frame_ctrl.md
TX_FRAME_CTRL -- requirements
Module: tx_frame_ctrl

Interface
REQ-001 Parameter SYM_LEN, default 320, meaning clk_80 cycles per OFDM symbol slot (80 samples at 20 MHz).
REQ-002 Parameter BIT_WIN, default 192, meaning PRBS bits per symbol (48 data subcarriers x 4 bits); must satisfy 0 < BIT_WIN < SYM_LEN and BIT_WIN % 4 == 0.
REQ-003 Parameter GAP_SYMS, default 2, meaning idle symbol slots appended after each frame; 0 allowed.
REQ-004 clk_80  in  1  80 MHz clock; the only clock used.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 start  in  1  single-cycle frame request.
REQ-007 num_sym  in  8  symbols in the requested frame, sampled with start.
REQ-008 abort  in  1  single-cycle request to end the frame early.
REQ-009 trig_en  out  1  bit-request enable to the PRBS source.
REQ-010 sym_start  out  1  one-cycle pulse on slot 0 of each payload symbol.
REQ-011 sym_idx  out  8  index of the current payload symbol, starting at 0.
REQ-012 last_sym  out  1  high throughout the final payload symbol.
REQ-013 busy  out  1  high whenever state != IDLE.
REQ-014 done  out  1  one-cycle frame-complete pulse.
REQ-015 aborted  out  1  high with done when the frame was cut short; otherwise low.
REQ-016 err  out  1  one-cycle pulse when a start is rejected.
REQ-017 frame_cnt  out  16  count of completed frames, wrapping modulo 2^16.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, SYMBOL, GAP and DONE.
REQ-019 Counters: slot_cnt counts 0..SYM_LEN-1; gap_cnt counts 0..GAP_SYMS*SYM_LEN-1; the latched num_sym is held in n_lat.
REQ-020 IDLE with start=1 and num_sym!=0: latch n_lat, clear sym_idx and slot_cnt, and enter SYMBOL on the next cycle.
REQ-021 IDLE with start=1 and num_sym==0: pulse err on the next cycle and remain in IDLE.
REQ-022 start while busy=1 SHALL be ignored: no err, and n_lat is unchanged.
REQ-023 trig_en SHALL be registered and high exactly in cycles where state==SYMBOL and slot_cnt<BIT_WIN, so each symbol requests exactly BIT_WIN contiguous bits.
REQ-024 sym_start SHALL be high exactly in cycles where state==SYMBOL and slot_cnt==0.
REQ-025 last_sym SHALL equal (state==SYMBOL and sym_idx==n_lat-1).
REQ-026 SYMBOL, slot_cnt==SYM_LEN-1, not the final symbol and no pending abort: increment sym_idx and wrap slot_cnt to 0.
REQ-027 SYMBOL, slot_cnt==SYM_LEN-1, and either the final symbol or a pending abort: go to GAP if GAP_SYMS>0, otherwise go to DONE.
REQ-028 An abort in SYMBOL SHALL set a pending flag; the current symbol completes in full, so no partial 4-bit QAM group is ever emitted.
REQ-029 An abort in IDLE, GAP or DONE SHALL be ignored.
REQ-030 An abort coinciding with slot_cnt==SYM_LEN-1 SHALL apply to the transition made in that same cycle.
REQ-031 GAP SHALL hold trig_en=0 for GAP_SYMS*SYM_LEN cycles and then go to DONE.
REQ-032 DONE SHALL last one cycle: done=1, aborted=pending flag, frame_cnt increments, pending flag clears, and the next state is IDLE.
REQ-033 A start in the DONE cycle SHALL be ignored.
REQ-034 Frame timing for start sampled at cycle 0: SYMBOL occupies cycles 1..SYM_LEN*N, GAP follows, and done is high at cycle SYM_LEN*(N+GAP_SYMS)+1.
REQ-035 sym_idx SHALL never exceed n_lat-1; N=255 runs its full length without wrapping.

Reset
REQ-036 With rst_n=0 at a clk_80 edge, the next cycle SHALL have state=IDLE and trig_en, sym_start, last_sym, busy, done, aborted and err all 0.
REQ-037 The same reset SHALL clear sym_idx, slot_cnt, gap_cnt, n_lat, the pending flag and frame_cnt to 0.
REQ-038 A reset mid-frame SHALL drop trig_en in the following cycle with no done pulse.
REQ-039 Inputs SHALL be ignored while rst_n=0.

Verification
REQ-040 Defaults, start with num_sym=1 at cycle 0 -> trig_en high cycles 1..192; busy high cycles 1..961; done=1 at cycle 961; frame_cnt=1.
REQ-041 num_sym=3 -> sym_start at cycles 1, 321 and 641; three 192-cycle trig_en windows separated by 128 low cycles; last_sym high for cycles 641..960; done at cycle 1601.
REQ-042 start with num_sym=0 -> err pulse at cycle 1; busy stays 0; then num_sym=2 during a frame -> ignored and the frame length is unchanged.
REQ-043 num_sym=5, abort at slot 50 of symbol 1 -> symbol 1 completes (384 trig_en cycles in total), GAP follows, done and aborted high at cycle 1281.
REQ-044 Reset at slot 100 of symbol 0 -> trig_en=0 next cycle, all outputs at reset values, and a fresh start behaves per REQ-040.
REQ-045 GAP_SYMS=0, num_sym=2 -> done at cycle 641, and a back-to-back start at cycle 642 gives a new sym_start at cycle 643.
